// File: rtl/day12_grant_decoder.sv
// Registered index-to-one-hot grant decoder with hold timeout and one idle gap cycle
// between grants, closing the request/grant loop behind the priority encoder.
module day12_grant_decoder #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned IDX_W    = $clog2(WIDTH),
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idx_valid_in,
  input  logic [IDX_W-1:0] idx_in,
  output logic             idx_ready_out,
  input  logic             done_in,
  output logic [WIDTH-1:0] grant_out,
  output logic             busy_out,
  output logic             timeout_out,
  output logic             err_out
);

  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  grant_q, grant_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;

  logic              accept;
  logic              idx_ok;
  logic              hold_expired;
  logic [WIDTH-1:0]  idx_onehot;

  assign accept       = idx_valid_in && (state_q == StIdle);
  // Only reachable as false when WIDTH is not a power of two.
  assign idx_ok       = 32'(idx_in) < WIDTH;
  assign hold_expired = (cnt_q == CntLast);
  assign idx_onehot   = {{(WIDTH-1){1'b0}}, 1'b1} << idx_in;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (idx_ok) begin
            grant_d = idx_onehot;
            cnt_d   = '0;
            state_d = StGrant;
          end else begin
            grant_d = '0;
            err_d   = 1'b1;
            state_d = StGap;
          end
        end
      end
      StGrant: begin
        cnt_d = cnt_q + CntW'(1);
        // done_in takes precedence over an expiring hold.
        if (done_in) begin
          grant_d = '0;
          state_d = StGap;
        end else if (hold_expired) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = StGap;
        end
      end
      StGap: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign idx_ready_out = (state_q == StIdle);
  assign busy_out      = (state_q != StIdle);
  assign grant_out     = grant_q;
  assign timeout_out   = timeout_q;
  assign err_out       = err_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_grant_only_in_grant : assert property (@(posedge clk) disable iff (!rst_n)
      (grant_q != '0) |-> (state_q == StGrant));

endmodule

// File: tb/tb_day12_grant_decoder.sv
// Bench for day12_grant_decoder: one 8-wide and one 6-wide instance on shared stimulus,
// checked every cycle against a transaction-level reference model.
module tb_day12_grant_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       idx_valid_in;
  logic [2:0] idx_in;
  logic       done_in;

  logic       ready_a, busy_a, to_a, err_a;
  logic [7:0] grant_a;
  logic       ready_b, busy_b, to_b, err_b;
  logic [5:0] grant_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  day12_grant_decoder #(.WIDTH(8), .HOLD_MAX(15)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx_valid_in (idx_valid_in),
    .idx_in       (idx_in),
    .idx_ready_out(ready_a),
    .done_in      (done_in),
    .grant_out    (grant_a),
    .busy_out     (busy_a),
    .timeout_out  (to_a),
    .err_out      (err_a)
  );

  day12_grant_decoder #(.WIDTH(6), .HOLD_MAX(4)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx_valid_in (idx_valid_in),
    .idx_in       (idx_in),
    .idx_ready_out(ready_b),
    .done_in      (done_in),
    .grant_out    (grant_b),
    .busy_out     (busy_b),
    .timeout_out  (to_b),
    .err_out      (err_b)
  );

  // Reference model: phase 0 = idle, 1 = granting, 2 = gap; held = grant cycles so far.
  int         m_width[2] = '{8, 6};
  int         m_hold[2]  = '{15, 4};
  int         m_phase[2];
  int         m_held[2];
  logic [7:0] m_grant[2];
  bit         m_to[2];
  bit         m_err[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_held[i]  = 0;
      m_grant[i] = 8'h00;
      m_to[i]    = 1'b0;
      m_err[i]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      m_to[i]  = 1'b0;
      m_err[i] = 1'b0;
      case (m_phase[i])
        0: if (idx_valid_in) begin
          if (int'(idx_in) < m_width[i]) begin
            m_grant[i] = 8'd1 << idx_in;
            m_held[i]  = 0;
            m_phase[i] = 1;
          end else begin
            m_err[i]   = 1'b1;
            m_phase[i] = 2;
          end
        end
        1: begin
          m_held[i]++;
          if (done_in) begin
            m_grant[i] = 8'h00;
            m_phase[i] = 2;
          end else if (m_held[i] == m_hold[i]) begin
            m_grant[i] = 8'h00;
            m_to[i]    = 1'b1;
            m_phase[i] = 2;
          end
        end
        default: m_phase[i] = 0;
      endcase
    end
  endtask

  task automatic check_all();
    check_val("a_grant", 32'(grant_a), 32'(m_grant[0]));
    check_val("a_ready", 32'(ready_a), 32'(m_phase[0] == 0));
    check_val("a_busy", 32'(busy_a), 32'(m_phase[0] != 0));
    check_val("a_timeout", 32'(to_a), 32'(m_to[0]));
    check_val("a_err", 32'(err_a), 32'(m_err[0]));
    check_val("a_onehot0", 32'($onehot0(grant_a)), 32'd1);
    check_val("b_grant", 32'(grant_b), 32'(m_grant[1]));
    check_val("b_ready", 32'(ready_b), 32'(m_phase[1] == 0));
    check_val("b_busy", 32'(busy_b), 32'(m_phase[1] != 0));
    check_val("b_timeout", 32'(to_b), 32'(m_to[1]));
    check_val("b_err", 32'(err_b), 32'(m_err[1]));
    check_val("b_onehot0", 32'($onehot0(grant_b)), 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         g;
    int         pos;
    bit         acc;
    bit         seen_to;
    logic [7:0] prev;
    logic [7:0] got_q[$];
    logic [2:0] seq[3] = '{3'd7, 3'd6, 3'd5};
    logic [7:0] exp_g[3] = '{8'h80, 8'h40, 8'h20};

    rst_n        = 1'b0;
    idx_valid_in = 1'b0;
    idx_in       = 3'd0;
    done_in      = 1'b0;
    model_reset();
    #2;
    check_all();
    #10 rst_n = 1'b1;
    cyc();

    // Index 5, done sampled three edges after accept.
    idx_in = 3'd5; idx_valid_in = 1'b1;
    g = 0;
    cyc();
    idx_valid_in = 1'b0;
    if (grant_a == 8'h20) g++;
    repeat (2) begin
      cyc();
      if (grant_a == 8'h20) g++;
    end
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    check_val("t1_len", 32'(g), 32'd3);
    check_val("t1_gap_ready", 32'(ready_a), 32'd0);
    cyc();
    check_val("t1_idle_ready", 32'(ready_a), 32'd1);
    repeat (4) cyc();

    // Index 0 with no done: full-length hold then timeout pulse.
    idx_in = 3'd0; idx_valid_in = 1'b1;
    cyc();
    idx_valid_in = 1'b0;
    g = (grant_a == 8'h01) ? 1 : 0;
    seen_to = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (to_a) begin
        seen_to = 1'b1;
        break;
      end
      if (grant_a == 8'h01) g++;
    end
    check_val("t2_len", 32'(g), 32'd15);
    check_val("t2_timeout_seen", 32'(seen_to), 32'd1);
    cyc();
    check_val("t2_timeout_pulse", 32'(to_a), 32'd0);
    repeat (4) cyc();

    // done arrives on the same edge the hold would expire.
    idx_in = 3'd3; idx_valid_in = 1'b1;
    cyc();
    idx_valid_in = 1'b0;
    repeat (14) cyc();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    check_val("t3_no_timeout", 32'(to_a), 32'd0);
    check_val("t3_released", 32'(grant_a), 32'd0);
    repeat (4) cyc();

    // Continuous valid, indices 7,6,5 presented in turn.
    pos = 0;
    prev = 8'h00;
    idx_valid_in = 1'b1;
    for (int k = 0; k < 200 && pos < 3; k++) begin
      idx_in = seq[pos];
      acc = ready_a;
      cyc();
      if (acc) pos++;
      if (grant_a != 8'h00 && prev == 8'h00) got_q.push_back(grant_a);
      prev = grant_a;
    end
    idx_valid_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (grant_a != 8'h00 && prev == 8'h00) got_q.push_back(grant_a);
      prev = grant_a;
    end
    check_val("t4_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) check_val("t4_grant", 32'(got_q[i]), 32'(exp_g[i]));
    end

    // Out-of-range index on the 6-wide instance.
    idx_in = 3'd6; idx_valid_in = 1'b1;
    cyc();
    idx_valid_in = 1'b0;
    check_val("t5_err", 32'(err_b), 32'd1);
    check_val("t5_grant", 32'(grant_b), 32'd0);
    cyc();
    check_val("t5_err_pulse", 32'(err_b), 32'd0);
    check_val("t5_idle", 32'(ready_b), 32'd1);
    repeat (20) cyc();

    // Asynchronous reset two cycles into a grant of index 2.
    idx_in = 3'd2; idx_valid_in = 1'b1;
    cyc();
    idx_valid_in = 1'b0;
    repeat (2) cyc();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("t6_grant_async", 32'(grant_a), 32'd0);
    check_val("t6_busy_async", 32'(busy_a), 32'd0);
    check_all();
    cyc();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    idx_in = 3'd4; idx_valid_in = 1'b1;
    cyc();
    idx_valid_in = 1'b0;
    check_val("t6_first_accept", 32'(grant_a), 32'h10);
    repeat (20) cyc();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      idx_valid_in = ($urandom_range(9) < 7);
      idx_in       = 3'($urandom_range(7));
      done_in      = ($urandom_range(4) == 0);
      if ($urandom_range(199) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
